// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    typedef logic [XLEN-1:0]    pc_t;
    typedef logic [INSTR_W-1:0] instr_t;

    localparam pc_t    RESET_PC_DEFAULT = 32'h0000_0000;
    localparam instr_t NOP_INSTR        = 32'h0000_0013;

    function automatic pc_t align_word(input pc_t addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: synchronous FIFO with flush; head word reads as zero when empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  instr_t                 wdata,
    output instr_t                 rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    instr_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage carries no reset; the empty-gate on rdata hides stale contents.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, credit-limited request issue, stale-response dropping
// on redirect, and a buffered valid/ready interface toward the decoder.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter pc_t RESET_PC = RESET_PC_DEFAULT,
    parameter int  DEPTH    = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    output logic   imem_req,
    output pc_t    imem_addr,
    input  logic   imem_gnt,
    input  logic   imem_rvalid,
    input  instr_t imem_rdata,
    input  logic   redirect,
    input  pc_t    redirect_pc,
    output logic   instr_valid,
    input  logic   instr_ready,
    output instr_t instr,
    output pc_t    instr_pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

    pc_t           fetch_pc_q, fetch_pc_d;
    pc_t           deliver_pc_q, deliver_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic          run_q, run_d;
    logic [CW-1:0] count;
    logic [CW:0]   in_use;
    logic          fire, rsp, keep, pop;
    pc_t           target;
    logic          unused_pc_lsbs;

    assign unused_pc_lsbs = ^redirect_pc[1:0];

    // Requests only start on the first clock after reset releases.
    assign in_use   = {1'b0, outstanding_q} + {1'b0, count};
    assign imem_req = run_q && !redirect && (in_use < CREDITS);

    always_comb begin
        run_d         = 1'b1;
        fire          = imem_req && imem_gnt;
        rsp           = imem_rvalid && (outstanding_q != '0);
        keep          = rsp && (drop_cnt_q == '0);
        pop           = instr_valid && instr_ready;
        target        = align_word(redirect_pc);
        outstanding_d = outstanding_q + CW'(fire) - CW'(rsp);
        drop_cnt_d    = drop_cnt_q - CW'(rsp && (drop_cnt_q != '0));
        fetch_pc_d    = fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
        deliver_pc_d  = pop ? deliver_pc_q + 32'd4 : deliver_pc_q;
        // Everything still in flight after this edge belongs to the old stream.
        if (redirect) begin
            drop_cnt_d   = outstanding_d;
            fetch_pc_d   = target;
            deliver_pc_d = target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            deliver_pc_q  <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            run_q         <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            deliver_pc_q  <= deliver_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            run_q         <= run_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (keep),
        .pop   (pop),
        .flush (redirect),
        .wdata (imem_rdata),
        .rdata (instr),
        .count (count)
    );

    assign imem_addr   = fetch_pc_q;
    assign instr_valid = (count != '0);
    assign instr_pc    = deliver_pc_q;

endmodule
